// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Initiator side of the instruction-memory read port. It owns the program
//   counter, drives the memory read address, captures the returned word one
//   cycle later, and presents fetched instructions to decode over a
//   valid/ready handshake. A small instruction buffer absorbs decode stalls,
//   so a word that is already in flight is never lost. A redirect (branch or
//   jump) reloads the PC and flushes both the buffered and in-flight fetches.
//
// Ports:
//   clk            in   1       clock, all logic on posedge
//   reset          in   1       synchronous, active-high
//   ra             out  ADDR_W  imem read address (registered PC), word aligned
//   rd             in   DATA_W  imem read data, valid one cycle after ra
//   redirect_valid in   1       load a new PC this cycle
//   redirect_pc    in   ADDR_W  redirect target, bits [1:0] forced to zero
//   if_valid       out  1       if_instr/if_pc hold a fetched instruction
//   if_instr       out  DATA_W  buffer-head instruction
//   if_pc          out  ADDR_W  byte address of if_instr
//   id_ready       in   1       decode takes the head when if_valid && id_ready
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 9'h000,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  // One extra bit so count + inflight cannot overflow before the compare.
  localparam int OCC_W = CNT_W + 1;

  localparam logic [OCC_W-1:0]  DEPTH_OCC  = OCC_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

  // RUN: a fetch may be issued. FULL: every buffer slot is either occupied
  // or reserved by the in-flight fetch, so nothing is issued until a pop.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Architectural state
  logic [ADDR_W-1:0] pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  state_t            state_r;

  // Buffer storage
  logic [DATA_W-1:0] buf_instr_r [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_r    [BUF_DEPTH];

  // Registered decode-facing outputs
  logic              if_valid_r;
  logic [DATA_W-1:0] if_instr_r;
  logic [ADDR_W-1:0] if_pc_r;

  // Next-state terms
  logic              pop_s;
  logic              capture_s;
  logic              issue_s;
  logic [OCC_W-1:0]  occ_s;
  logic [OCC_W-1:0]  occ_next_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [PTR_W-1:0]  rd_ptr_next_s;
  logic [PTR_W-1:0]  wr_ptr_next_s;
  state_t            state_next_s;
  logic [DATA_W-1:0] head_instr_next_s;
  logic [ADDR_W-1:0] head_pc_next_s;
  logic [ADDR_W-1:0] redirect_target_s;
  logic [ADDR_W-1:0] reset_target_s;

  assign ra       = pc_r;
  assign if_valid = if_valid_r;
  assign if_instr = if_instr_r;
  assign if_pc    = if_pc_r;

  // Handshake, issue decision and buffer bookkeeping for the coming edge.
  always_comb begin
    pop_s             = if_valid_r & id_ready;
    capture_s         = inflight_r;
    redirect_target_s = redirect_pc & ALIGN_MASK;
    reset_target_s    = RESET_PC & ALIGN_MASK;

    // Slots that stay committed after this edge if nothing new is issued.
    occ_s = OCC_W'(count_r) + OCC_W'(inflight_r) - OCC_W'(pop_s);

    case (state_r)
      ST_RUN:  issue_s = (occ_s < DEPTH_OCC);
      // In FULL, count + inflight equals the depth, so only a pop frees a slot.
      ST_FULL: issue_s = pop_s;
      default: issue_s = 1'b0;
    endcase

    count_next_s = count_r + CNT_W'(capture_s) - CNT_W'(pop_s);

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    if (capture_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    occ_next_s = OCC_W'(count_next_s) + OCC_W'(issue_s);
    if (occ_next_s == DEPTH_OCC) begin
      state_next_s = ST_FULL;
    end else begin
      state_next_s = ST_RUN;
    end

    // The head after this edge is the word being captured whenever it lands
    // in the slot the read pointer will point at (buffer empty, or drained to
    // empty by this pop); otherwise it is already in storage.
    if (capture_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_instr_next_s = rd;
      head_pc_next_s    = inflight_pc_r;
    end else begin
      head_instr_next_s = buf_instr_r[rd_ptr_next_s];
      head_pc_next_s    = buf_pc_r[rd_ptr_next_s];
    end
  end

  // Control FSM: PC, in-flight tracking, buffer pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= reset_target_s;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      state_r       <= ST_RUN;
      if_valid_r    <= 1'b0;
      if_instr_r    <= {DATA_W{1'b0}};
      if_pc_r       <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      // Flush: buffered words and the in-flight read are all stale.
      pc_r          <= redirect_target_s;
      inflight_r    <= 1'b0;
      inflight_pc_r <= inflight_pc_r;
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      state_r       <= ST_RUN;
      if_valid_r    <= 1'b0;
      if_instr_r    <= if_instr_r;
      if_pc_r       <= if_pc_r;
    end else begin
      if (issue_s) begin
        inflight_r    <= 1'b1;
        inflight_pc_r <= pc_r;
        pc_r          <= pc_r + PC_STEP;
      end else begin
        // Stalled: ra holds, so the memory keeps returning the same word,
        // which is simply not captured next cycle.
        inflight_r    <= 1'b0;
        inflight_pc_r <= inflight_pc_r;
        pc_r          <= pc_r;
      end
      count_r    <= count_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      wr_ptr_r   <= wr_ptr_next_s;
      state_r    <= state_next_s;
      if_valid_r <= (count_next_s != CNT_ZERO);
      if_instr_r <= head_instr_next_s;
      if_pc_r    <= head_pc_next_s;
    end
  end

  // Buffer storage: the returning word and its address are written at the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_r[i] <= {DATA_W{1'b0}};
        buf_pc_r[i]    <= {ADDR_W{1'b0}};
      end
    end else if (capture_s && !redirect_valid) begin
      buf_instr_r[wr_ptr_r] <= rd;
      buf_pc_r[wr_ptr_r]    <= inflight_pc_r;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_r[i] <= buf_instr_r[i];
        buf_pc_r[i]    <= buf_pc_r[i];
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit with a registered-read memory
// model (mem[i] = 0x1000_0000 + i), followed by a randomised handshake and
// redirect phase checked against an expected PC stream.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd = 32'h0000_0000;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  logic [DATA_W-1:0] mem [128];

  int n_compared   = 0;
  int n_mismatched = 0;

  instruction_fetch_unit #(
    .ADDR_W   (9),
    .DATA_W   (32),
    .RESET_PC (9'h000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ra            (ra),
    .rd            (rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory.
  always @(posedge clk) rd <= mem[ra[8:2]];

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0] exp_pc;
  int                pops;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 9'h000;
    id_ready       = 1'b1;

    // Test 1: reset state, latency and streaming order.
    tick();
    tick();
    check_value("t1_rst_valid", 32'(if_valid), 32'd0);
    check_value("t1_rst_ra", 32'(ra), 32'h000);
    check_value("t1_rst_pc", 32'(if_pc), 32'h000);
    check_value("t1_rst_instr", if_instr, 32'h0000_0000);
    reset = 1'b0;
    tick();
    check_value("t1_lat_valid", 32'(if_valid), 32'd0);
    check_value("t1_lat_ra", 32'(ra), 32'h004);
    tick();
    check_value("t1_v0", 32'(if_valid), 32'd1);
    check_value("t1_pc0", 32'(if_pc), 32'h000);
    check_value("t1_i0", if_instr, 32'h1000_0000);
    tick();
    check_value("t1_pc1", 32'(if_pc), 32'h004);
    check_value("t1_i1", if_instr, 32'h1000_0001);
    tick();
    check_value("t1_pc2", 32'(if_pc), 32'h008);
    check_value("t1_i2", if_instr, 32'h1000_0002);

    // Test 2: decode stall fills the buffer, ra freezes, no drop on release.
    id_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check_value("t2_ra_frozen", 32'(ra), 32'h010);
    check_value("t2_hold_valid", 32'(if_valid), 32'd1);
    check_value("t2_hold_pc", 32'(if_pc), 32'h008);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_value("t2_rel_valid", 32'(if_valid), 32'd1);
      check_value("t2_rel_pc", 32'(if_pc), 32'h00C + 32'(4 * k));
      check_value("t2_rel_instr", if_instr, 32'h1000_0003 + 32'(k));
    end

    // Test 3: redirect while the buffer is full.
    id_ready = 1'b0;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 9'h043;
    tick();
    redirect_valid = 1'b0;
    check_value("t3_flush_valid", 32'(if_valid), 32'd0);
    check_value("t3_ra", 32'(ra), 32'h040);
    id_ready = 1'b1;
    tick();
    check_value("t3_gap_valid", 32'(if_valid), 32'd0);
    tick();
    check_value("t3_v", 32'(if_valid), 32'd1);
    check_value("t3_pc0", 32'(if_pc), 32'h040);
    check_value("t3_i0", if_instr, 32'h1000_0010);
    tick();
    check_value("t3_pc1", 32'(if_pc), 32'h044);
    check_value("t3_i1", if_instr, 32'h1000_0011);

    // Test 4: redirect near the top of the address space, PC wraps.
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1F8;
    tick();
    redirect_valid = 1'b0;
    check_value("t4_flush_valid", 32'(if_valid), 32'd0);
    check_value("t4_ra", 32'(ra), 32'h1F8);
    tick();
    tick();
    check_value("t4_pc0", 32'(if_pc), 32'h1F8);
    check_value("t4_i0", if_instr, 32'h1000_007E);
    tick();
    check_value("t4_pc1", 32'(if_pc), 32'h1FC);
    check_value("t4_i1", if_instr, 32'h1000_007F);
    tick();
    check_value("t4_pc2", 32'(if_pc), 32'h000);
    check_value("t4_i2", if_instr, 32'h1000_0000);
    tick();
    check_value("t4_pc3", 32'(if_pc), 32'h004);
    check_value("t4_i3", if_instr, 32'h1000_0001);

    // Test 5: reset in the middle of a full-buffer stall.
    id_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_value("t5_stall_valid", 32'(if_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_value("t5_rst_valid", 32'(if_valid), 32'd0);
    check_value("t5_rst_ra", 32'(ra), 32'h000);
    reset    = 1'b0;
    id_ready = 1'b1;
    tick();
    check_value("t5_lat_valid", 32'(if_valid), 32'd0);
    tick();
    check_value("t5_v", 32'(if_valid), 32'd1);
    check_value("t5_pc0", 32'(if_pc), 32'h000);
    check_value("t5_i0", if_instr, 32'h1000_0000);
    tick();
    check_value("t5_pc1", 32'(if_pc), 32'h004);
    check_value("t5_i1", if_instr, 32'h1000_0001);

    // Test 6: random decode readiness with occasional redirects.
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    exp_pc = 9'h000;
    pops   = 0;
    for (int c = 0; c < 2000; c++) begin
      id_ready       = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 9'($urandom_range(0, 511));
      if (if_valid && id_ready) begin
        check_value("t6_pc", 32'(if_pc), 32'(exp_pc));
        check_value("t6_instr", if_instr, mem[exp_pc[8:2]]);
        exp_pc = exp_pc + 9'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc & 9'h1FC;
      tick();
    end
    redirect_valid = 1'b0;
    check_value("t6_pop_count", 32'(pops >= 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
